// File: rtl/bcd_to_binary_seq_if.sv
// Request/result bundle for the sequential BCD-to-binary converter.
// The master drives a conversion request and the slave returns the result.
interface bcd_to_binary_seq_if #(
  parameter int NUM_DIGITS = 3,
  parameter int OUT_W      = 8
);
  logic                    start;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [OUT_W-1:0]        binary;
  logic                    valid;
  logic                    busy;
  logic                    overflow;
  logic                    digit_err;

  modport master (
    output start, bcd_in,
    input  binary, valid, busy, overflow, digit_err
  );

  modport slave (
    input  start, bcd_in,
    output binary, valid, busy, overflow, digit_err
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Reverse double-dabble BCD-to-binary converter, one result bit per clock.
// Invalid digits skip the shift phase; oversized results saturate to all-ones.
module bcd_to_binary_seq #(
  parameter int NUM_DIGITS = 3,
  parameter int OUT_W      = 8
) (
  input logic                clk,
  input logic                rst_n,
  bcd_to_binary_seq_if.slave bus
);
  localparam int RAW_W = $clog2(10**NUM_DIGITS);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CAT_W = BCD_W + RAW_W;
  localparam int CNT_W = $clog2(RAW_W + 1);
  localparam int EXT_W = (RAW_W > OUT_W) ? RAW_W : OUT_W;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [RAW_W-1:0]   raw_q, raw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   bin_q, bin_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic [CAT_W-1:0]   shifted;

  function automatic logic nibble_bad(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Shift right, then pull each digit that reached 8 or more back by 3.
  function automatic logic [CAT_W-1:0] dabble_step(input logic [CAT_W-1:0] v);
    logic [CAT_W-1:0] s;
    s = v >> 1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s[RAW_W+4*i +: 4] >= 4'd8) s[RAW_W+4*i +: 4] = s[RAW_W+4*i +: 4] - 4'd3;
    end
    return s;
  endfunction

  function automatic logic is_ovf(input logic [RAW_W-1:0] r);
    return EXT_W'(r) > EXT_W'({OUT_W{1'b1}});
  endfunction

  function automatic logic [OUT_W-1:0] sat_out(input logic [RAW_W-1:0] r);
    logic [EXT_W-1:0] e;
    e = EXT_W'(r);
    if (is_ovf(r)) return '1;
    return e[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      raw_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      raw_q   <= raw_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    raw_d   = raw_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    shifted = dabble_step({bcd_q, raw_q});
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          bcd_d = bus.bcd_in;
          raw_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          err_d = 1'b0;
          if (nibble_bad(bus.bcd_in)) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        {bcd_d, raw_d} = shifted;
        cnt_d          = cnt_q + CNT_W'(1);
        // The result register is loaded from the final shift, not from raw_q.
        if (cnt_q == CNT_W'(RAW_W - 1)) begin
          bin_d   = sat_out(shifted[RAW_W-1:0]);
          ovf_d   = is_ovf(shifted[RAW_W-1:0]);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.valid     = (state_q == S_DONE);
    bus.busy      = (state_q != S_IDLE);
    bus.binary    = bin_q;
    bus.overflow  = ovf_q;
    bus.digit_err = err_q;
  end
endmodule
